// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory-side handshake unit (mem_bus_ctrl).
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_timeout_cnt.sv
// ACCESS-phase watchdog: hit is high during the TIMEOUT-th consecutive enabled cycle.
module mem_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             hit_r;

  // count ACCESS cycles; hit_r is precomputed so it lines up with the limit cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      hit_r <= 1'b0;
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
      hit_r <= (LAST == {CNT_W{1'b0}});
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
      hit_r <= ((cnt_r + CNT_W'(1)) == LAST);
    end else begin
      cnt_r <= cnt_r;
      hit_r <= hit_r;
    end
  end

  assign hit = hit_r;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side handshake between MAR/MDR and a variable-latency memory.
// Optional ACCESS watchdog with bus_err reporting is built in when MEM_TIMEOUT_EN is defined.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] mar_in,
  input  logic [DATA_W-1:0] mdr_in,
  output logic [DATA_W-1:0] m_bus_in,
  output logic              busy,
  output logic              done,
  output logic              bus_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e            state_r;
  logic              op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              busy_r;
  logic              done_r;
  logic              bus_err_r;
  logic              re_r;
  logic              we_r;
  logic              timeout_hit_s;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk   (CLK),
    .rst_n (CLR),
    .clear (state_r != ST_ACCESS),
    .enable(state_r == ST_ACCESS),
    .hit   (timeout_hit_s)
  );
`else
  assign timeout_hit_s = 1'b0;
  // without the watchdog TIMEOUT has no effect; this block only keeps it referenced
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // request capture, strobe generation and completion sequencing
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_RD;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      rdata_r   <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bus_err_r <= 1'b0;
      re_r      <= 1'b0;
      we_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r    <= 1'b0;
          bus_err_r <= 1'b0;
          // a simultaneous read is dropped in favour of the write
          if (wr_req) begin
            addr_r  <= mar_in;
            wdata_r <= mdr_in;
            op_r    <= OP_WR;
            we_r    <= 1'b1;
            re_r    <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_ACCESS;
          end else if (rd_req) begin
            addr_r  <= mar_in;
            op_r    <= OP_RD;
            re_r    <= 1'b1;
            we_r    <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            if (op_r == OP_RD) begin
              rdata_r <= mem_rdata;
            end else begin
              rdata_r <= rdata_r;
            end
            re_r    <= 1'b0;
            we_r    <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (timeout_hit_s) begin
            re_r      <= 1'b0;
            we_r      <= 1'b0;
            done_r    <= 1'b1;
            bus_err_r <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            state_r <= ST_ACCESS;
          end
        end
        ST_DONE: begin
          done_r    <= 1'b0;
          bus_err_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          re_r      <= 1'b0;
          we_r      <= 1'b0;
          done_r    <= 1'b0;
          bus_err_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_bus_in  = rdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign bus_err   = bus_err_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_re    = re_r;
  assign mem_we    = we_r;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: transaction-level model plus directed scenarios.
module tb_mem_bus_ctrl;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [15:0] mar_in = 16'h0000;
  logic [15:0] mdr_in = 16'h0000;
  logic [15:0] mem_rdata = 16'hFFFF;
  logic        mem_ready = 1'b0;
  logic [15:0] m_bus_in;
  logic        busy;
  logic        done;
  logic        bus_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;

  int n_checks = 0;
  int n_pass   = 0;

  mem_bus_ctrl #(
    .ADDR_W (16),
    .DATA_W (16),
    .TIMEOUT(TO)
  ) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .mar_in   (mar_in),
    .mdr_in   (mdr_in),
    .m_bus_in (m_bus_in),
    .busy     (busy),
    .done     (done),
    .bus_err  (bus_err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction model: a pending access, a one-cycle completion slot, and held registers.
  logic        m_active  = 1'b0;
  logic        m_in_done = 1'b0;
  logic        m_op      = 1'b0;
  logic        m_err     = 1'b0;
  logic [15:0] m_addr    = 16'h0000;
  logic [15:0] m_wdata   = 16'h0000;
  logic [15:0] m_bus     = 16'h0000;
  int          m_acc     = 0;

  always @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      m_active  <= 1'b0;
      m_in_done <= 1'b0;
      m_op      <= 1'b0;
      m_err     <= 1'b0;
      m_addr    <= 16'h0000;
      m_wdata   <= 16'h0000;
      m_bus     <= 16'h0000;
      m_acc     <= 0;
    end else if (m_in_done) begin
      m_in_done <= 1'b0;
      m_err     <= 1'b0;
    end else if (m_active) begin
      m_acc <= m_acc + 1;
      if (mem_ready) begin
        if (!m_op) m_bus <= mem_rdata;
        m_active  <= 1'b0;
        m_in_done <= 1'b1;
      end
`ifdef MEM_TIMEOUT_EN
      else if (m_acc + 1 == TO) begin
        m_active  <= 1'b0;
        m_in_done <= 1'b1;
        m_err     <= 1'b1;
      end
`endif
    end else if (rd_req || wr_req) begin
      m_active <= 1'b1;
      m_op     <= wr_req;
      m_addr   <= mar_in;
      if (wr_req) m_wdata <= mdr_in;
      m_acc    <= 0;
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    chk("busy",      16'(busy),    16'(m_active | m_in_done));
    chk("done",      16'(done),    16'(m_in_done));
    chk("bus_err",   16'(bus_err), 16'(m_in_done & m_err));
    chk("mem_re",    16'(mem_re),  16'(m_active & ~m_op));
    chk("mem_we",    16'(mem_we),  16'(m_active & m_op));
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("m_bus_in",  m_bus_in,  m_bus);
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [15:0] data, input int waits);
    rd_req = 1'b1;
    mar_in = addr;
    tick();
    rd_req = 1'b0;
    repeat (waits) tick();
    mem_ready = 1'b1;
    mem_rdata = data;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 16'hFFFF;
    chk("rd_done", 16'(done), 16'h0001);
    chk("rd_data", m_bus_in, data);
    tick();
    chk("rd_idle", 16'(busy), 16'h0000);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    #1 CLR = 1'b0;
    #2;
    chk("rst_busy",   16'(busy),   16'h0000);
    chk("rst_done",   16'(done),   16'h0000);
    chk("rst_re",     16'(mem_re), 16'h0000);
    chk("rst_we",     16'(mem_we), 16'h0000);
    chk("rst_addr",   mem_addr,    16'h0000);
    chk("rst_m_bus",  m_bus_in,    16'h0000);
    tick();
    tick();
    CLR = 1'b1;
    tick();

    // 1: read, zero wait states
    rd_req = 1'b1;
    mar_in = 16'h0040;
    tick();
    rd_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    chk("t1_re",   16'(mem_re), 16'h0001);
    chk("t1_addr", mem_addr,    16'h0040);
    chk("t1_nodone", 16'(done), 16'h0000);
    tick();
    mem_ready = 1'b0;
    mem_rdata = 16'hFFFF;
    chk("t1_done", 16'(done),   16'h0001);
    chk("t1_re_off", 16'(mem_re), 16'h0000);
    chk("t1_data", m_bus_in,    16'hBEEF);
    tick();
    chk("t1_done_off", 16'(done), 16'h0000);
    chk("t1_busy_off", 16'(busy), 16'h0000);

    // 2: write, three wait states
    wr_req = 1'b1;
    mar_in = 16'h0080;
    mdr_in = 16'h1234;
    tick();
    wr_req = 1'b0;
    mdr_in = 16'h0000;
    mar_in = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      chk("t2_we_wait", 16'(mem_we), 16'h0001);
      chk("t2_wdata",   mem_wdata,   16'h1234);
      tick();
    end
    mem_ready = 1'b1;
    chk("t2_we_last", 16'(mem_we), 16'h0001);
    chk("t2_addr",    mem_addr,    16'h0080);
    tick();
    mem_ready = 1'b0;
    chk("t2_done",  16'(done), 16'h0001);
    chk("t2_m_bus", m_bus_in,  16'hBEEF);
    tick();

    // 3a: simultaneous read and write -> write only
    rd_req = 1'b1;
    wr_req = 1'b1;
    mar_in = 16'h0100;
    mdr_in = 16'h5555;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    chk("t3a_we", 16'(mem_we), 16'h0001);
    chk("t3a_re", 16'(mem_re), 16'h0000);
    chk("t3a_wdata", mem_wdata, 16'h5555);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("t3a_done", 16'(done), 16'h0001);
    tick();

    // 3b: second read during ACCESS is ignored
    rd_req = 1'b1;
    mar_in = 16'h0200;
    tick();
    mar_in = 16'h0300;
    tick();
    rd_req = 1'b0;
    chk("t3b_addr", mem_addr, 16'h0200);
    mem_ready = 1'b1;
    mem_rdata = 16'h0AAA;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 16'hFFFF;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) n++;
      tick();
    end
    chk("t3b_done_count", 16'(n), 16'h0001);
    chk("t3b_data", m_bus_in, 16'h0AAA);

    // 4: asynchronous reset in the second ACCESS cycle
    rd_req = 1'b1;
    mar_in = 16'h0400;
    tick();
    rd_req = 1'b0;
    tick();
    #1 CLR = 1'b0;
    #1;
    chk("t4_re",    16'(mem_re), 16'h0000);
    chk("t4_busy",  16'(busy),   16'h0000);
    chk("t4_done",  16'(done),   16'h0000);
    chk("t4_m_bus", m_bus_in,    16'h0000);
    chk("t4_addr",  mem_addr,    16'h0000);
    tick();
    chk("t4_no_done", 16'(done), 16'h0000);
    CLR = 1'b1;
    tick();
    do_read(16'h0500, 16'h0777, 1);

    // 6: back-to-back reads issued in the IDLE cycle after each done
    do_read(16'h0010, 16'h0001, 0);
    do_read(16'h0014, 16'h0002, 0);
    chk("t6_last", m_bus_in, 16'h0002);

`ifdef MEM_TIMEOUT_EN
    // 5: watchdog abort, then completion exactly on the limit cycle
    rd_req = 1'b1;
    mar_in = 16'h0600;
    tick();
    rd_req = 1'b0;
    n = 0;
    while (mem_re && n < 20) begin
      n++;
      tick();
    end
    chk("t5_re_cycles", 16'(n),     16'h0004);
    chk("t5_done",      16'(done),  16'h0001);
    chk("t5_err",       16'(bus_err), 16'h0001);
    chk("t5_m_bus",     m_bus_in,   16'h0002);
    tick();
    chk("t5_err_off",   16'(bus_err), 16'h0000);
    rd_req = 1'b1;
    mar_in = 16'h0610;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    tick();
    mem_ready = 1'b1;
    mem_rdata = 16'h4444;
    chk("t5b_re", 16'(mem_re), 16'h0001);
    tick();
    mem_ready = 1'b0;
    mem_rdata = 16'hFFFF;
    chk("t5b_done", 16'(done),    16'h0001);
    chk("t5b_err",  16'(bus_err), 16'h0000);
    chk("t5b_data", m_bus_in,     16'h4444);
    tick();
`else
    // without the watchdog a stalled read simply waits
    rd_req = 1'b1;
    mar_in = 16'h0600;
    tick();
    rd_req = 1'b0;
    repeat (10) tick();
    chk("nt_still_re", 16'(mem_re), 16'h0001);
    chk("nt_no_done",  16'(done),   16'h0000);
    mem_ready = 1'b1;
    mem_rdata = 16'h4444;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 16'hFFFF;
    chk("nt_done", 16'(done),    16'h0001);
    chk("nt_err",  16'(bus_err), 16'h0000);
    chk("nt_data", m_bus_in,     16'h4444);
    tick();
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
